// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - trap/interrupt sequencer: CSR writes for mepc/mcause, then redirect to mtvec
//
// Sits beside the main decoder. When an exception or an enabled interrupt is
// detected, it stalls the core, writes mepc and mcause (and optionally mtval)
// through the CSR write port, and then redirects the PC to mtvec. MRET inside
// the handler returns to mepc in the same cycle.
//
// Optional build macro: TRAP_SEQ_MTVAL_EN adds an mtval write (0x343) after mcause.
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   instr_valid_i                         current instruction executes this cycle
//   illegal_instr_i, ecall_i, ebreak_i,
//   mret_i                                decoder flags
//   pc_i, instr_i                         PC and word of the current instruction
//   irq_req_i, mie_i                      level interrupt requests and enables
//   mtvec_i, mepc_i                       CSR values
//   trap_stall_o                          freeze PC, RF write and memory request
//   csr_we_o, csr_addr_o, csr_wdata_o     CSR write port
//   pc_redirect_o, pc_target_o            PC redirect
//   irq_ack_o                             one-hot acknowledge of the serviced IRQ
//   in_handler_o                          handler active, IRQs masked
module trap_sequencer #(
    parameter int IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               instr_valid_i,
    input  logic               illegal_instr_i,
    input  logic               ecall_i,
    input  logic               ebreak_i,
    input  logic               mret_i,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        instr_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [IRQ_NUM-1:0] mie_i,
    input  logic [31:0]        mtvec_i,
    input  logic [31:0]        mepc_i,
    output logic               trap_stall_o,
    output logic               csr_we_o,
    output logic [11:0]        csr_addr_o,
    output logic [31:0]        csr_wdata_o,
    output logic               pc_redirect_o,
    output logic [31:0]        pc_target_o,
    output logic [IRQ_NUM-1:0] irq_ack_o,
    output logic               in_handler_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_MEPC   = 3'd1;
    localparam logic [2:0] WR_MCAUSE = 3'd2;
`ifdef TRAP_SEQ_MTVAL_EN
    localparam logic [2:0] WR_MTVAL  = 3'd3;
`endif
    localparam logic [2:0] REDIRECT  = 3'd4;
    localparam logic [2:0] HANDLER   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [31:0]        epc_q, cause_q;
    logic [IRQ_NUM-1:0] ack_q;

    logic               in_h, detect, is_illegal, exc, irq_hit, take, ret;
    logic [IRQ_NUM-1:0] pend, irq_onehot;
    logic [4:0]         irq_k;
    logic [31:0]        cause_d;

    assign in_h       = (state_q == HANDLER);
    // Reset gates detection so every output reads 0 while rst_ni is low,
    // even with decoder flags still asserted.
    assign detect     = rst_ni & instr_valid_i & ((state_q == IDLE) | in_h);
    // MRET outside a handler has no return address: treat it as illegal.
    assign is_illegal = illegal_instr_i | (mret_i & ~in_h);
    assign exc        = is_illegal | ecall_i | ebreak_i;
    assign pend       = irq_req_i & mie_i;
    assign irq_hit    = ~in_h & (|pend);
    assign take       = detect & (exc | irq_hit);
    assign ret        = detect & in_h & mret_i & ~exc;

    // Lowest pending enabled interrupt wins: scan downward, last hit sticks.
    always_comb begin
        irq_k      = '0;
        irq_onehot = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pend[i]) begin
                irq_k         = 5'(i);
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (is_illegal)   cause_d = 32'd2;
        else if (ecall_i) cause_d = 32'd11;
        else if (ebreak_i) cause_d = 32'd3;
        else              cause_d = {1'b1, 31'd16 + 31'(irq_k)};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (take) state_d = WR_MEPC;
            WR_MEPC:   state_d = WR_MCAUSE;
`ifdef TRAP_SEQ_MTVAL_EN
            WR_MCAUSE: state_d = WR_MTVAL;
            WR_MTVAL:  state_d = REDIRECT;
`else
            WR_MCAUSE: state_d = REDIRECT;
`endif
            REDIRECT:  state_d = HANDLER;
            HANDLER: begin
                if (take)     state_d = WR_MEPC;
                else if (ret) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                epc_q   <= pc_i;
                cause_q <= cause_d;
                ack_q   <= exc ? '0 : irq_onehot;
            end
        end
    end

`ifdef TRAP_SEQ_MTVAL_EN
    logic [31:0] tval_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tval_q <= '0;
        end else if (take) begin
            tval_q <= is_illegal ? instr_i : 32'd0;
        end
    end
`else
    logic unused_instr;
    assign unused_instr = ^instr_i;
`endif

    always_comb begin
        trap_stall_o  = take;
        csr_we_o      = 1'b0;
        csr_addr_o    = '0;
        csr_wdata_o   = '0;
        pc_redirect_o = 1'b0;
        pc_target_o   = '0;
        irq_ack_o     = '0;
        in_handler_o  = 1'b0;
        case (state_q)
            WR_MEPC: begin
                trap_stall_o = 1'b1;
                csr_we_o     = 1'b1;
                csr_addr_o   = 12'h341;
                csr_wdata_o  = epc_q;
            end
            WR_MCAUSE: begin
                trap_stall_o = 1'b1;
                csr_we_o     = 1'b1;
                csr_addr_o   = 12'h342;
                csr_wdata_o  = cause_q;
            end
`ifdef TRAP_SEQ_MTVAL_EN
            WR_MTVAL: begin
                trap_stall_o = 1'b1;
                csr_we_o     = 1'b1;
                csr_addr_o   = 12'h343;
                csr_wdata_o  = tval_q;
            end
`endif
            REDIRECT: begin
                trap_stall_o  = 1'b1;
                pc_redirect_o = 1'b1;
                pc_target_o   = mtvec_i;
                irq_ack_o     = ack_q;
            end
            HANDLER: begin
                in_handler_o = 1'b1;
                if (ret) begin
                    pc_redirect_o = 1'b1;
                    pc_target_o   = mepc_i;
                end
            end
            default: ;
        endcase
    end

endmodule
